// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation codes, FSM states and helpers for alu_muldiv
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SRA   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_XOR   = 4'b1101;
    localparam logic [3:0] ALU_MFHI  = 4'b1110;
    localparam logic [3:0] ALU_MFLO  = 4'b1111;

    // Iterative unit opcode: the low two bits of the ALU control code
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    function automatic logic is_muldiv(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_MULTU) ||
               (code == ALU_DIV)  || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier and restoring divider
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic               neg_q, neg_r;
    logic [SHW-1:0]     cnt;
    logic               prep, run;

    logic               is_div, is_signed, a_neg, b_neg;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // Operand signs and one multiply/divide step
    always_comb begin
        is_div    = (op_r == MD_DIV) || (op_r == MD_DIVU);
        is_signed = (op_r == MD_MULT) || (op_r == MD_DIV);
        a_neg     = is_signed & a_r[WIDTH-1];
        b_neg     = is_signed & b_r[WIDTH-1];
        sum       = {1'b0, acc_hi} + ({1'b0, mag_b} & {(WIDTH+1){acc_lo[0]}});
        shifted   = {acc_hi, acc_lo[WIDTH-1]};
        diff      = shifted - {1'b0, mag_b};
        hi_nxt    = sum[WIDTH:1];
        lo_nxt    = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            // diff[WIDTH] is the borrow: set means the trial subtraction fails
            if (!diff[WIDTH]) begin
                hi_nxt = diff[WIDTH-1:0];
                lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction of the finished magnitudes
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        hi_out   = prod_fix[2*WIDTH-1:WIDTH];
        lo_out   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_r == '0) begin
                hi_out = a_r;
                lo_out = '1;
            end else begin
                hi_out = neg_r ? -acc_hi : acc_hi;
                lo_out = neg_q ? -acc_lo : acc_lo;
            end
        end
    end

    assign done = run && (cnt == LAST);

    // Operand capture, magnitude preparation and iteration
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            prep   <= 1'b0;
            run    <= 1'b0;
        end else if (start) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
            prep <= 1'b1;
        end else if (prep) begin
            prep   <= 1'b0;
            run    <= 1'b1;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= a_neg ? -a_r : a_r;
            mag_b  <= b_neg ? -b_r : b_r;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
        end else if (run) begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - registered MIPS ALU with iterative multiply/divide and HI/LO
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state, state_nxt;
    logic             accept, start, md_done;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] simple_res, md_hi, md_lo;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign start    = accept && is_muldiv(alu_control);
    assign shamt    = data1[SHW-1:0];

    muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (alu_control[1:0]),
        .a      (data1),
        .b      (data2),
        .done   (md_done),
        .hi_out (md_hi),
        .lo_out (md_lo)
    );

    // Single-cycle operation results
    always_comb begin
        simple_res = '0;
        case (alu_control)
            ALU_AND:  simple_res = data1 & data2;
            ALU_OR:   simple_res = data1 | data2;
            ALU_ADD:  simple_res = data1 + data2;
            ALU_SUB:  simple_res = data1 - data2;
            ALU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            ALU_NOR:  simple_res = ~(data1 | data2);
            ALU_XOR:  simple_res = data1 ^ data2;
            ALU_SLL:  simple_res = data2 << shamt;
            ALU_SRL:  simple_res = data2 >> shamt;
            ALU_SRA:  simple_res = $signed(data2) >>> shamt;
            ALU_MFHI: simple_res = hi;
            ALU_MFLO: simple_res = lo;
            default:  simple_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (md_done) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result, flag and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_muldiv(alu_control)) begin
                out_valid <= 1'b1;
                result    <= simple_res;
                zero      <= (simple_res == '0);
            end else if (state == FIX) begin
                out_valid <= 1'b1;
                hi        <= md_hi;
                lo        <= md_lo;
                result    <= md_lo;
                zero      <= (md_lo == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, zero;
    logic [31:0] data1, data2, result, hi, lo;
    logic [3:0]  alu_control;

    logic        in_valid16, in_ready16, out_valid16, zero16;
    logic [15:0] data1_16, data2_16, result16, hi16, lo16;
    logic [3:0]  alu_control16;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          dmy;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data1(data1), .data2(data2), .alu_control(alu_control),
        .out_valid(out_valid), .result(result), .zero(zero), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .data1(data1_16), .data2(data2_16), .alu_control(alu_control16),
        .out_valid(out_valid16), .result(result16), .zero(zero16), .hi(hi16), .lo(lo16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every out_valid pulse pops one expected entry
    always @(negedge clk) begin
        if (out_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out_valid result=%h cycle=%0d", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (result !== mon_e.res || zero !== mon_e.z || hi !== mon_e.hi ||
                    lo !== mon_e.lo || cyc != mon_e.due) begin
                    fails++;
                    $display("FAIL out_check got r=%h z=%b hi=%h lo=%h cyc=%0d want r=%h z=%b hi=%h lo=%h cyc=%0d",
                             result, zero, hi, lo, cyc,
                             mon_e.res, mon_e.z, mon_e.hi, mon_e.lo, mon_e.due);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r);
        longint          p;
        longint unsigned pu;
        int              sh;
        sh = int'(a[4:0]);
        r  = '0;
        case (op)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_NOR:  r = ~(a | b);
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = b << sh;
            ALU_SRL:  r = b >> sh;
            ALU_SRA:  r = $signed(b) >>> sh;
            ALU_MFHI: r = m_hi;
            ALU_MFLO: r = m_lo;
            ALU_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = p;
                r = m_lo;
            end
            ALU_MULTU: begin
                pu = {32'h0, a} * {32'h0, b};
                {m_hi, m_lo} = pu;
                r = m_lo;
            end
            default: begin
                if (b == 32'h0) begin
                    m_lo = '1;
                    m_hi = a;
                end else if (op == ALU_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = '0;
                end else if (op == ALU_DIV) begin
                    m_lo = $signed(a) / $signed(b);
                    m_hi = $signed(a) % $signed(b);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                r = m_lo;
            end
        endcase
    endtask

    // Presents one operation; returns the cycle index of the accepting edge
    task automatic accept_op(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                             output int acc);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout got in_ready=%b want 1", in_ready);
        end
        alu_control = op;
        data1       = d1;
        data2       = d2;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc      = cyc;
    endtask

    task automatic push(input logic [31:0] r, input int due);
        exp_t e;
        e.res = r;
        e.z   = (r == 32'h0);
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.due = due;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         output int acc);
        logic [31:0] r;
        accept_op(op, d1, d2, acc);
        model(op, d1, d2, r);
        push(r, is_muldiv(op) ? acc + W + 2 : acc);
    endtask

    task automatic issue_k(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] k_res);
        int acc;
        accept_op(op, d1, d2, acc);
        push(k_res, acc);
    endtask

    task automatic issue_mdk(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] k_hi, input logic [31:0] k_lo);
        int acc;
        accept_op(op, d1, d2, acc);
        m_hi = k_hi;
        m_lo = k_lo;
        push(k_lo, acc + W + 2);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; alu_control = '0; data1 = '0; data2 = '0;
        in_valid16 = 1'b0; alu_control16 = '0; data1_16 = '0; data2_16 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            fails++; $display("FAIL reset_result got r=%h z=%b want r=0 z=1", result, zero);
        end
        tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            fails++; $display("FAIL reset_hilo got hi=%h lo=%h want 0 0", hi, lo);
        end
    endtask

    task automatic test_simple();
        issue_k(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        issue_k(ALU_SUB, 32'h5, 32'h5, 32'h0);
        issue_k(ALU_SRA, 32'h24, 32'hF000_0000, 32'hFF00_0000);
        issue_k(ALU_SRL, 32'h24, 32'hF000_0000, 32'h0F00_0000);
        issue_k(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
        issue_k(ALU_SLL, 32'hFFFF_FFE3, 32'h0000_0001, 32'h0000_0008);
        issue_k(ALU_NOR, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0);
        issue_k(ALU_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
        drain();
    endtask

    task automatic test_mult();
        int busy_bad = 0;
        issue_mdk(ALU_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // Cycles 1..W+2 after acceptance: busy, requests must be ignored
        for (int i = 0; i < W + 2; i++) begin
            if (in_ready !== 1'b0) busy_bad++;
            alu_control = ALU_ADD;
            data1       = $urandom;
            data2       = $urandom;
            in_valid    = i[0];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++;
        if (busy_bad != 0) begin
            fails++; $display("FAIL mult_busy_in_ready got %0d high cycles want 0", busy_bad);
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mult_done_cycle got in_ready=%b out_valid=%b want 1 1", in_ready, out_valid);
        end
        issue_mdk(ALU_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE);
        drain();
    endtask

    task automatic test_div();
        logic [3:0] md_ops [4];
        md_ops[0] = ALU_MULT; md_ops[1] = ALU_MULTU; md_ops[2] = ALU_DIV; md_ops[3] = ALU_DIVU;
        issue_mdk(ALU_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue_mdk(ALU_DIVU, 32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF);
        issue_mdk(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        for (int i = 0; i < 6; i++) begin
            issue(md_ops[i % 4], $urandom, (i == 5) ? 32'h0 : ($urandom >> (i * 5)), dmy);
        end
        drain();
    endtask

    task automatic test_mfhi_mflo();
        int acc_m, acc_h, acc_l;
        issue(ALU_MULT, $urandom, $urandom, acc_m);
        issue(ALU_MFHI, 32'h0, 32'h0, acc_h);
        issue(ALU_MFLO, 32'h0, 32'h0, acc_l);
        tests++;
        if (acc_h != acc_m + W + 3 || acc_l != acc_m + W + 4) begin
            fails++;
            $display("FAIL mfhi_accept_cycle got %0d,%0d want %0d,%0d",
                     acc_h - acc_m, acc_l - acc_m, W + 3, W + 4);
        end
        drain();
    endtask

    task automatic test_abort();
        int acc;
        int seen = 0;
        issue(ALU_MULTU, 32'hDEAD_BEEF, 32'h1234_5677, acc);
        // ITER counter reaches 10 in cycle 12 after acceptance
        repeat (11) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_handshake got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            fails++; $display("FAIL abort_hilo got hi=%h lo=%h want 0 0", hi, lo);
        end
        repeat (W + 6) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL abort_no_out_valid got %0d pulses want 0", seen);
        end
        issue(ALU_MFLO, 32'h0, 32'h0, dmy);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [12];
        int         acc [8];
        ops[0] = ALU_AND; ops[1] = ALU_OR;  ops[2]  = ALU_ADD; ops[3]  = ALU_SUB;
        ops[4] = ALU_SLT; ops[5] = ALU_NOR; ops[6]  = ALU_XOR; ops[7]  = ALU_SLL;
        ops[8] = ALU_SRL; ops[9] = ALU_SRA; ops[10] = ALU_MFHI; ops[11] = ALU_MFLO;
        issue(ALU_MULT, 32'h8765_4321, 32'hFEDC_BA98, dmy);
        for (int i = 0; i < 8; i++) begin
            issue(ops[$urandom_range(11, 0)], $urandom, $urandom, acc[i]);
        end
        tests++;
        if (acc[7] - acc[0] != 7) begin
            fails++; $display("FAIL b2b_accept_span got %0d want 7", acc[7] - acc[0]);
        end
        drain();
    endtask

    task automatic run16(input logic [3:0] op, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [15:0] k_hi, input logic [15:0] k_lo);
        int n = 1;
        alu_control16 = op;
        data1_16      = d1;
        data2_16      = d2;
        in_valid16    = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        while (out_valid16 !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != 19) begin
            fails++; $display("FAIL w16_latency op=%b got %0d want 19", op, n);
        end
        tests++;
        if (hi16 !== k_hi || lo16 !== k_lo || result16 !== k_lo || in_ready16 !== 1'b1) begin
            fails++;
            $display("FAIL w16_result op=%b got hi=%h lo=%h r=%h rdy=%b want hi=%h lo=%h r=%h rdy=1",
                     op, hi16, lo16, result16, in_ready16, k_hi, k_lo, k_lo);
        end
    endtask

    task automatic test_width16();
        run16(ALU_MULT, 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB);
        run16(ALU_DIV,  16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD);
    endtask

    initial begin
        test_reset();
        test_simple();
        test_mult();
        test_div();
        test_mfhi_mflo();
        test_abort();
        test_back_to_back();
        test_width16();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
